// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with hold-until-release grants,
// a mandatory dead cycle between owners and a MAX_HOLD forced-release timeout.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD - 1);
    state_t           state_q;
    logic [2:0]       ptr_q, idx_q;
    logic [CNT_W-1:0] hold_q;
    logic [7:0]       gnt_q, rot;
    logic             valid_q, timeout_q, rel, expire;
    logic [2:0]       off, win_d;
    // Rotate so bit 0 is the current highest-priority requester.
    always_comb begin
        rot = 8'({req, req} >> ptr_q);
        off = '0;
        for (int i = 7; i >= 0; i--) if (rot[i]) off = 3'(i);
        win_d  = ptr_q + off;
        rel    = done | ~req[idx_q];
        expire = !rel && hold_q == LAST;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (state_q == IDLE) begin
                if (|req) begin
                    state_q <= GRANT;
                    idx_q   <= win_d;
                    gnt_q   <= 8'd1 << win_d;
                    valid_q <= 1'b1;
                    hold_q  <= '0;
                end
            end else if (rel || expire) begin
                state_q   <= IDLE;
                gnt_q     <= '0;
                valid_q   <= 1'b0;
                ptr_q     <= idx_q + 3'd1;
                timeout_q <= expire;
            end else begin
                hold_q <= hold_q + 1'b1;
            end
        end
    end
    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign timeout   = timeout_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed vector table plus hand-written timeout,
// simultaneity and async-reset sequences for rr_arbiter8.
module tb_rr_arbiter8;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid, timeout;
    int total = 0, bad = 0;

    rr_arbiter8 #(.MAX_HOLD(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } vec_t;
    vec_t tbl[64];
    int   n = 0;

    task automatic add(input logic [7:0] r, input logic d, input logic [7:0] g,
                       input logic [2:0] i, input logic v, input logic t);
        tbl[n] = '{req: r, done: d, gnt: g, idx: i, valid: v, to: t};
        n++;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [7:0] g, input logic [2:0] i,
                           input logic v, input logic t);
        chk({name, ".gnt"}, int'(gnt), int'(g));
        chk({name, ".idx"}, int'(gnt_idx), int'(i));
        chk({name, ".valid"}, int'(gnt_valid), int'(v));
        chk({name, ".timeout"}, int'(timeout), int'(t));
    endtask

    task automatic step(input logic [7:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            add(8'hFF, 1'b1, 8'h00, 3'(k), 1'b0, 1'b0);
            add(8'hFF, 1'b0, 8'(1 << ((k + 1) % 8)), 3'((k + 1) % 8), 1'b1, 1'b0);
        end
        add(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        add(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
        add(8'h20, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0);
        add(8'h05, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
        add(8'h05, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        add(8'h05, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
        add(8'h05, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0);
        add(8'h00, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0);
        add(8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0);
        add(8'h00, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0);
        add(8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
        add(8'h1F, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
        add(8'hEF, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0);
        add(8'h00, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0);

        req = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(8'hFF, 1'b0);
        chk_all("first_grant", 8'h01, 3'd0, 1'b1, 1'b0);

        for (int v = 0; v < n; v++) begin
            step(tbl[v].req, tbl[v].done);
            chk_all($sformatf("vec%0d", v), tbl[v].gnt, tbl[v].idx, tbl[v].valid, tbl[v].to);
        end

        // Timeout: ptr=5, requester 3 alone holds for exactly 16 cycles.
        step(8'h08, 1'b0);
        chk_all("to_grant", 8'h08, 3'd3, 1'b1, 1'b0);
        for (int c = 1; c < 16; c++) begin
            step(8'h08, 1'b0);
            chk_all($sformatf("to_hold%0d", c), 8'h08, 3'd3, 1'b1, 1'b0);
        end
        step(8'h08, 1'b0);
        chk_all("to_fire", 8'h00, 3'd3, 1'b0, 1'b1);
        step(8'h08, 1'b0);
        chk_all("to_regrant", 8'h08, 3'd3, 1'b1, 1'b0);

        // done on the final hold cycle wins over timeout.
        for (int c = 1; c < 16; c++) step(8'h08, 1'b0);
        chk_all("sim_last", 8'h08, 3'd3, 1'b1, 1'b0);
        step(8'h08, 1'b1);
        chk_all("sim_done", 8'h00, 3'd3, 1'b0, 1'b0);

        // Async reset mid-grant, then arbitration restarts from ptr=0.
        step(8'h20, 1'b0);
        chk_all("ar_grant", 8'h20, 3'd5, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_all("ar_async", 8'h00, 3'd0, 1'b0, 1'b0);
        req = 8'h24;
        #1 rst_n = 1'b1;
        step(8'h24, 1'b0);
        chk_all("ar_restart", 8'h04, 3'd2, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
